// File: rtl/coo_pkg.sv
// Shared types and helpers for the dense-to-COO encoder (FP8 1-4-3 elements).
package coo_pkg;

  localparam int unsigned FP8_EXP_W = 4;
  localparam int unsigned FP8_MAN_W = 3;
  localparam int unsigned COO_IDX_W = 32;

  typedef logic [7:0]           fp8_t;
  typedef logic [COO_IDX_W-1:0] coo_idx_t;

  typedef struct packed {
    fp8_t     data;
    coo_idx_t row;
    coo_idx_t col;
  } coo_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT,
    ST_DONE
  } coo_state_e;

  function automatic logic [FP8_EXP_W-1:0] fp8_exp(input fp8_t x);
    return x[FP8_MAN_W +: FP8_EXP_W];
  endfunction

  // Sign is ignored, so negative zero (8'h80) also counts as zero.
  function automatic logic fp8_is_zero(input fp8_t x);
    return (fp8_exp(x) == '0) && (x[FP8_MAN_W-1:0] == '0);
  endfunction

endpackage

// File: rtl/coo_lsb_finder.sv
// Priority encoder over a W-bit mask: lowest set index, any-set and single-set flags.
module coo_lsb_finder #(
  parameter  int unsigned W  = 64,
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  mask,
  output logic [IW-1:0] idx,
  output logic          any,
  output logic          single
);

  always_comb begin
    idx = '0;
    for (int unsigned i = W; i > 0; i--) begin
      if (mask[i-1]) idx = IW'(i - 1);
    end
  end

  assign any    = |mask;
  // Clearing the lowest set bit leaves nothing only when exactly one bit was set.
  assign single = any && ((mask & (mask - W'(1))) == '0);

endmodule

// File: rtl/dense_to_coo_encoder.sv
// Dense NxN FP8 tile to row-major COO (data,row,col) stream with nnz/overflow report.
// Optional build macro COO_PRUNE_THRESH_EN adds prune_exp: elements with exp < prune_exp are dropped.
module dense_to_coo_encoder
  import coo_pkg::*;
#(
  parameter  int unsigned N       = 8,
  parameter  int unsigned DATA_W  = 8,
  parameter  int unsigned IDX_W   = 32,
  parameter  int unsigned MAX_NNZ = 8,
  localparam int unsigned CNT_W   = $clog2(N*N+1)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [N-1:0][N-1:0][DATA_W-1:0]    in_matrix,
`ifdef COO_PRUNE_THRESH_EN
  input  logic [3:0]                         prune_exp,
`endif
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_W-1:0]                  out_data,
  output logic [IDX_W-1:0]                   out_row,
  output logic [IDX_W-1:0]                   out_col,
  output logic                               out_last,
  output logic                               done,
  output logic [CNT_W-1:0]                   nnz,
  output logic                               overflow
);

  localparam int unsigned NN     = N * N;
  localparam int unsigned LIDX_W = (NN > 1) ? $clog2(NN) : 1;

  coo_state_e                   state_q, state_d;
  logic [NN-1:0][DATA_W-1:0]    tile_q, tile_d;
  logic [NN-1:0]                mask_q, mask_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [CNT_W-1:0]             nnz_q, nnz_d;
  logic                         overflow_q, overflow_d;
  logic                         live_q, live_d;

  logic [NN-1:0]                in_mask;
  logic [NN-1:0][DATA_W-1:0]    in_flat;
  logic [LIDX_W-1:0]            lsb_idx;
  logic                         any_set;
  logic                         single_set;
  logic                         last_c;
  coo_entry_t                   entry_c;

  always_comb begin
    in_mask = '0;
    in_flat = '0;
    for (int unsigned i = 0; i < NN; i++) begin
      in_flat[i] = in_matrix[i / N][i % N];
`ifdef COO_PRUNE_THRESH_EN
      in_mask[i] = !fp8_is_zero(fp8_t'(in_flat[i])) &&
                   (fp8_exp(fp8_t'(in_flat[i])) >= prune_exp);
`else
      in_mask[i] = !fp8_is_zero(fp8_t'(in_flat[i]));
`endif
    end
  end

  coo_lsb_finder #(
    .W (NN)
  ) u_finder (
    .mask   (mask_q),
    .idx    (lsb_idx),
    .any    (any_set),
    .single (single_set)
  );

  always_comb begin
    state_d    = state_q;
    tile_d     = tile_q;
    mask_d     = mask_q;
    count_d    = count_q;
    nnz_d      = nnz_q;
    overflow_d = overflow_q;
    live_d     = 1'b1;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    last_c     = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        in_ready = live_q;
        if (in_valid && live_q) begin
          tile_d  = in_flat;
          mask_d  = in_mask;
          count_d = '0;
          if (in_mask == '0) begin
            state_d    = ST_DONE;
            nnz_d      = '0;
            overflow_d = 1'b0;
          end else begin
            state_d = ST_EMIT;
          end
        end
      end

      ST_EMIT: begin
        out_valid = 1'b1;
        last_c    = single_set || (count_q == CNT_W'(MAX_NNZ - 1));
        if (out_ready) begin
          mask_d[lsb_idx] = 1'b0;
          count_d         = count_q + CNT_W'(1);
          if (last_c) begin
            state_d    = ST_DONE;
            nnz_d      = count_q + CNT_W'(1);
            // Anything left after the final beat was cut off by the entry limit.
            overflow_d = (mask_d != '0);
          end
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      tile_q     <= '0;
      mask_q     <= '0;
      count_q    <= '0;
      nnz_q      <= '0;
      overflow_q <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tile_q     <= tile_d;
      mask_q     <= mask_d;
      count_q    <= count_d;
      nnz_q      <= nnz_d;
      overflow_q <= overflow_d;
      live_q     <= live_d;
    end
  end

  // Entry fields are forced to zero whenever no beat is offered.
  always_comb begin
    entry_c = '0;
    if (out_valid) begin
      entry_c.data = fp8_t'(tile_q[lsb_idx]);
      entry_c.row  = coo_idx_t'(lsb_idx / LIDX_W'(N));
      entry_c.col  = coo_idx_t'(lsb_idx % LIDX_W'(N));
    end
  end

  assign out_data = DATA_W'(entry_c.data);
  assign out_row  = IDX_W'(entry_c.row);
  assign out_col  = IDX_W'(entry_c.col);
  assign out_last = last_c;
  assign nnz      = nnz_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_dense_to_coo_encoder.sv
// Scoreboard bench for dense_to_coo_encoder: random tiles vs. a row-major reference model.
module tb_dense_to_coo_encoder;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [7:0][7:0][7:0] in_matrix = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [7:0]        out_data;
  logic [31:0]       out_row;
  logic [31:0]       out_col;
  logic              out_last;
  logic              done;
  logic [6:0]        nnz;
  logic              overflow;
`ifdef COO_PRUNE_THRESH_EN
  logic [3:0]        prune_exp = 4'd0;
`endif

  dense_to_coo_encoder #(
    .N       (8),
    .DATA_W  (8),
    .IDX_W   (32),
    .MAX_NNZ (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_matrix (in_matrix),
`ifdef COO_PRUNE_THRESH_EN
    .prune_exp (prune_exp),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
    .done      (done),
    .nnz       (nnz),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] d; int r; int c; bit last; } beat_t;
  typedef struct { int nnz; bit ov; } done_t;
  typedef logic [7:0] tile_t [8][8];

  beat_t exp_q[$];
  done_t done_q[$];

  int total = 0, bad = 0;
  int negcnt = 0, acc_neg = 0, done_neg = 0, done_cnt = 0, beats_seen = 0;
  bit rnd_mode = 0;
  int cur_prune = 0;
  int hold_nnz = 0;
  bit hold_ov = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // An element survives if it is not +/-0 and its exponent reaches the threshold.
  function automatic bit kept(input logic [7:0] e, input int pe);
    int ex;
    ex = int'(e[6:3]);
    if (e[6:0] == 7'd0) return 0;
    if (ex < pe) return 0;
    return 1;
  endfunction

  always begin
    @(posedge clk);
    #1;
    out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: pops and compares on every handshake and done pulse.
  initial begin
    bit         stall_prev;
    logic [7:0] h_d;
    logic [31:0] h_r, h_c;
    logic       h_l;
    beat_t      b;
    done_t      d;
    stall_prev = 0;
    h_d = '0; h_r = '0; h_c = '0; h_l = 0;
    forever begin
      @(negedge clk);
      negcnt++;
      if (!rst_n) begin
        stall_prev = 0;
      end else begin
        if (stall_prev) begin
          chk("valid_held", {63'd0, out_valid}, 64'd1);
          if (out_valid)
            chk("stall_stable", {out_data, out_row, out_col, out_last}, {h_d, h_r, h_c, h_l});
        end
        if (out_valid && out_ready) begin
          stall_prev = 0;
          beats_seen++;
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 64'd1, 64'd0);
          end else begin
            b = exp_q.pop_front();
            chk("beat_data", {56'd0, out_data}, {56'd0, b.d});
            chk("beat_row", {32'd0, out_row}, 64'(b.r));
            chk("beat_col", {32'd0, out_col}, 64'(b.c));
            chk("beat_last", {63'd0, out_last}, {63'd0, b.last});
          end
        end else if (out_valid) begin
          stall_prev = 1;
          h_d = out_data; h_r = out_row; h_c = out_col; h_l = out_last;
        end else begin
          stall_prev = 0;
        end
        if (done) begin
          if (done_q.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
          end else begin
            d = done_q.pop_front();
            chk("done_nnz", {57'd0, nnz}, 64'(d.nnz));
            chk("done_overflow", {63'd0, overflow}, {63'd0, d.ov});
            hold_nnz = d.nnz;
            hold_ov  = d.ov;
          end
          chk("beats_left_at_done", 64'(exp_q.size()), 64'd0);
          done_neg = negcnt;
          done_cnt++;
        end
        if (in_valid && in_ready) acc_neg = negcnt;
      end
    end
  end

  task automatic issue_tile(input tile_t m, output int k, output int start);
    int    cnt;
    int    w;
    beat_t lst[$];
    cnt = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        if (kept(m[r][c], cur_prune)) begin
          cnt++;
          if (lst.size() < 8) lst.push_back('{m[r][c], r, c, 1'b0});
        end
    k = lst.size();
    if (k > 0) lst[k-1].last = 1;
    foreach (lst[i]) exp_q.push_back(lst[i]);
    done_q.push_back('{k, cnt > 8});

    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    chk("nnz_hold", {57'd0, nnz}, 64'(hold_nnz));
    chk("overflow_hold", {63'd0, overflow}, {63'd0, hold_ov});

    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        in_matrix[r][c] = m[r][c];
`ifdef COO_PRUNE_THRESH_EN
    prune_exp = 4'(cur_prune);
`endif
    start    = done_cnt;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        in_matrix[r][c] = 8'($urandom);
`ifdef COO_PRUNE_THRESH_EN
    prune_exp = 4'($urandom);
`endif
  endtask

  task automatic run_tile(input tile_t m);
    int k, start, w;
    issue_tile(m, k, start);
    w = 0;
    while (done_cnt == start && w < 3000) begin
      @(posedge clk); #1; w++;
    end
    if (done_cnt == start) begin
      chk("done_timeout", 64'd0, 64'd1);
    end else begin
      if (!rnd_mode) chk("done_latency", 64'(done_neg - acc_neg), 64'(k + 1));
      chk("in_ready_after_done", {63'd0, in_ready}, 64'd1);
    end
  endtask

  function automatic tile_t diag_tile();
    tile_t m;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        m[r][c] = (r == c) ? 8'h38 : 8'h00;
    return m;
  endfunction

  function automatic logic [7:0] rand_nz();
    logic [7:0] v;
    v = 8'($urandom_range(1, 255));
    while (v[6:0] == 7'd0) v = 8'($urandom_range(1, 255));
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tile_t m;
    int    k, start, w, b0, dens;

    #12;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_nnz", {57'd0, nnz}, 64'd0);
    chk("rst_overflow", {63'd0, overflow}, 64'd0);
    chk("rst_out_fields", {out_data, out_row, out_col, out_last}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_release", {63'd0, in_ready}, 64'd1);

    // Diagonal tile, constant ready.
    run_tile(diag_tile());

    // All-zero tile mixing +0 and -0.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        m[r][c] = ((r + c) % 2 == 0) ? 8'h80 : 8'h00;
    run_tile(m);

    // Twelve scattered nonzeros: truncation after eight.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        m[r][c] = 8'h00;
    for (int j = 0; j < 12; j++)
      m[(j * 5) / 8][(j * 5) % 8] = rand_nz();
    run_tile(m);

    // Diagonal tile under random backpressure.
    rnd_mode = 1;
    run_tile(diag_tile());

    // Random tiles of varying density, alternating backpressure.
    for (int t = 0; t < 20; t++) begin
      rnd_mode = t[0];
      dens = int'($urandom_range(0, 40));
`ifdef COO_PRUNE_THRESH_EN
      cur_prune = int'($urandom_range(0, 9));
`endif
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) begin
          if (int'($urandom_range(0, 99)) < dens)
            m[r][c] = 8'($urandom);
          else
            m[r][c] = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00;
        end
      run_tile(m);
    end
    rnd_mode  = 0;
    cur_prune = 0;

    // Reset after three beats, then a clean tile.
    b0 = beats_seen;
    issue_tile(diag_tile(), k, start);
    w = 0;
    while (beats_seen < b0 + 3 && w < 200) begin
      @(posedge clk); #1; w++;
    end
    chk("three_beats_before_reset", 64'(beats_seen - b0), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("reset_drops_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("reset_fields_zero", {out_data, out_row, out_col, out_last}, 64'd0);
    exp_q.delete();
    done_q.delete();
    hold_nnz = 0;
    hold_ov  = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
    run_tile(diag_tile());

`ifdef COO_PRUNE_THRESH_EN
    // Threshold 7 keeps exponents 7 and 8, drops exponent 6.
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        m[r][c] = 8'h00;
    m[0][1] = 8'h38;
    m[2][3] = 8'h30;
    m[5][5] = 8'h40;
    cur_prune = 7;
    run_tile(m);
    cur_prune = 0;
`endif

    repeat (3) @(posedge clk);
    chk("queues_drained", 64'(exp_q.size() + done_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
